// File: rtl/ctrl_seq_controller.sv
// ctrl_seq_controller
// Restartable sequencer for the pipelined vector/matrix multiplier datapath.
// A run is one or more passes. Each pass counts 0..LAST (LAST = N + PIPE_LAT)
// over non-stalled cycles and is followed immediately by the next pass.
// The block raises done/end_signal on normal completion and aborted on abort.
//
// Ports:
//   i_clk, i_rstn      clock (rising edge), asynchronous active-low reset
//   i_start            run request, accepted only when idle
//   i_num_passes       pass count, latched on an accepted start (0 acts as 1)
//   i_stall, i_abort   freeze / terminate an active run
//   o_busy             high while a run is active
//   o_state_count      cycle index within the pass, all-ones when idle
//   o_pass_idx         current pass index
//   o_feed_en, o_acc_clr, o_out_valid   decoded datapath strobes
//   o_done, o_aborted  one-cycle completion / abort pulses
//   o_end_signal       sticky completion flag, cleared by the next start
module ctrl_seq_controller #(
    parameter int N        = 32,
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 7,
    parameter int PASS_W   = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [PASS_W-1:0] i_num_passes,
    input  logic              i_stall,
    input  logic              i_abort,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_state_count,
    output logic [PASS_W-1:0] o_pass_idx,
    output logic              o_feed_en,
    output logic              o_acc_clr,
    output logic              o_out_valid,
    output logic              o_done,
    output logic              o_end_signal,
    output logic              o_aborted
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N + PIPE_LAT);
    localparam logic [CNT_W-1:0] C_N    = CNT_W'(N);
    // All-ones can never equal a live count because 2^CNT_W-1 > LAST.
    localparam logic [CNT_W-1:0] C_IDLE = '1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic [PASS_W-1:0] r_pass;
    logic [PASS_W-1:0] r_passes_m1;
    logic              r_done;
    logic              r_end;
    logic              r_aborted;
    logic              w_active;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= S_IDLE;
            r_count     <= C_IDLE;
            r_pass      <= '0;
            r_passes_m1 <= '0;
            r_done      <= 1'b0;
            r_end       <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_count <= C_IDLE;
                    if (i_start) begin
                        r_state     <= S_RUN;
                        r_count     <= '0;
                        r_pass      <= '0;
                        r_end       <= 1'b0;
                        r_passes_m1 <= (i_num_passes == '0) ? '0 : i_num_passes - 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_abort) begin
                        r_state   <= S_IDLE;
                        r_count   <= C_IDLE;
                        r_pass    <= '0;
                        r_aborted <= 1'b1;
                    end else if (!i_stall) begin
                        if (r_count != C_LAST) begin
                            r_count <= r_count + 1'b1;
                        end else if (r_pass != r_passes_m1) begin
                            // Next pass starts with no idle gap.
                            r_count <= '0;
                            r_pass  <= r_pass + 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_count <= C_IDLE;
                            r_pass  <= '0;
                            r_done  <= 1'b1;
                            r_end   <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy        = (r_state == S_RUN);
    assign o_state_count = r_count;
    assign o_pass_idx    = r_pass;
    assign o_done        = r_done;
    assign o_end_signal  = r_end;
    assign o_aborted     = r_aborted;

    // Strobes are suppressed while stalled so the datapath sees no duplicates.
    assign w_active    = o_busy & ~i_stall;
    assign o_feed_en   = w_active & (r_count < C_N);
    assign o_acc_clr   = w_active & (r_count == '0);
    assign o_out_valid = w_active & (r_count == C_LAST);

endmodule

// File: doc/ctrl_seq_controller.md
Name: ctrl_seq_controller

Overview:
- Parametrised sequence controller for the pipelined vector/matrix multiplier datapath.
- Replaces the fixed 32-wide run-to-end counter with a restartable sequencer that has:
  - configurable matrix size and pipeline latency;
  - multi-pass (tile) operation;
  - stall and abort support;
  - a start/busy/done handshake.
- Drives the operand feeders, accumulator clear and output capture strobes.

Parameters:
- N, 32, matrix size (operand elements fed per pass); N >= 1.
- PIPE_LAT, 2, datapath pipeline latency in cycles from last feed to result valid; PIPE_LAT >= 0.
- CNT_W, 7, state_count width; must satisfy 2^CNT_W - 1 > N + PIPE_LAT.
- PASS_W, 4, width of the pass-count input and pass index.

Ports:
- clk  input  1  clock, rising-edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request a run; sampled every cycle, accepted only when idle.
- num_passes  input  PASS_W  number of passes, latched on an accepted start; 0 is treated as 1.
- stall  input  1  freezes sequencing while high.
- abort  input  1  terminates an active run.
- busy  output  1  high from the cycle after an accepted start until the run ends.
- state_count  output  CNT_W  cycle index within the current pass; all-ones when idle.
- pass_idx  output  PASS_W  current pass, starting at 0.
- feed_en  output  1  operand feed strobe.
- acc_clr  output  1  accumulator clear strobe.
- out_valid  output  1  result capture strobe.
- done  output  1  one-cycle pulse on normal completion.
- end_signal  output  1  sticky completion flag.
- aborted  output  1  one-cycle pulse when a run is aborted.

Behaviour:
- Constant: LAST = N + PIPE_LAT.
- States: IDLE and RUN, encoded by busy.
- Reset (rstn low, asynchronous):
  - state IDLE;
  - state_count = all-ones;
  - pass_idx = 0, busy = 0, done = 0, end_signal = 0, aborted = 0.
- IDLE:
  - state_count is held at all-ones.
  - start=1 → next cycle: RUN, busy=1, state_count=0, pass_idx=0, end_signal=0.
  - On that same start, latch passes_m1 = max(num_passes,1) - 1.
  - abort and stall have no effect in IDLE.
- RUN, priority abort > stall > advance:
  - abort=1: next cycle IDLE, state_count = all-ones, busy=0, aborted=1 for one cycle. done stays 0 and end_signal stays 0.
  - stall=1 (no abort): state_count and pass_idx hold. Decoded strobes are gated low during stall.
  - Advance, state_count < LAST: state_count + 1.
  - Advance, state_count == LAST and pass_idx < passes_m1: state_count = 0 and pass_idx + 1. No idle gap between passes.
  - Advance, state_count == LAST and pass_idx == passes_m1: next cycle IDLE, state_count = all-ones, pass_idx = 0, busy=0, done=1 for one cycle, end_signal=1.
- end_signal stays high until reset or the next accepted start; it clears in the same edge that sets busy.
- start while busy is ignored: no restart and no re-latch of num_passes.
- start in the cycle where done=1 is accepted, since the block is already IDLE. This gives back-to-back runs with a one-cycle gap.
- Decoded strobes are combinational from registers and stall:
  - feed_en = busy & ~stall & (state_count < N).
  - acc_clr = busy & ~stall & (state_count == 0).
  - out_valid = busy & ~stall & (state_count == LAST).
- Timing per run: each pass spans LAST+1 non-stalled RUN cycles. A run of P passes has busy high for P*(LAST+1) + stall cycles.
- Arithmetic: all counters are unsigned and cannot wrap while busy, because of the CNT_W constraint. The idle value all-ones must never match a valid count.
- Reset during a run returns to the reset values immediately. No done or aborted pulse is produced.

Test Plan (N=32, PIPE_LAT=2, LAST=34):
- Single pass, start at edge t with num_passes=1:
  - busy rises at t+1; state_count steps 0..34 over t+1..t+35;
  - feed_en high for 32 cycles, acc_clr high at t+1 only, out_valid high at t+35;
  - done pulse and end_signal=1 at t+36, state_count=0x7F.
- Three passes (num_passes=3):
  - pass_idx steps 0→1→2 with state_count wrapping 34→0 without a gap;
  - 3 acc_clr and 3 out_valid pulses;
  - busy for 105 cycles, then a single done.
- Stall: stall=1 for 5 cycles at state_count=10 → count holds at 10 with feed_en low; the run completes 5 cycles later and all strobe counts are unchanged.
- Abort at state_count=20 with stall=1 in the same cycle → next cycle IDLE, state_count=0x7F, aborted=1, done=0, end_signal=0.
- Restart and ignored start:
  - start pulsed mid-run → ignored, and num_passes changes have no effect.
  - start asserted in the done cycle → new run begins, and end_signal clears when busy rises.
- Reset and zero passes:
  - rstn low at state_count=15 → outputs return to reset values asynchronously.
  - After release, num_passes=0 runs exactly one pass.
